window_gen_3x3: RTL

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

---
 rtl/window_gen_3x3.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streams raster-order 8-bit pixels and emits every interior
// 3x3 neighbourhood as a registered window. Two line buffers supply the two
// previous lines; a 3x3 shift register supplies the two previous columns.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Upstream: a pixel is taken when in_valid && in_ready. Downstream: a
// window is taken when out_valid && out_ready. While out_valid is high and
// out_ready is low, every output holds and in_ready stays low, so no pixel can
// disturb the pending window. in_ready is purely combinational from out_valid
// and out_ready.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pixel,
  output logic       in_ready,
  output logic [7:0] out_pixel_1,
  output logic [7:0] out_pixel_2,
  output logic [7:0] out_pixel_3,
  output logic [7:0] out_pixel_4,
  output logic [7:0] out_pixel_5,
  output logic [7:0] out_pixel_6,
  output logic [7:0] out_pixel_7,
  output logic [7:0] out_pixel_8,
  output logic [7:0] out_pixel_9,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Position of the pixel on the input this cycle; SOF forces (0,0).
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  logic accept;
  logic produce;
  logic last_pix;

  // Line buffers: lb1 holds line row-1, lb2 holds line row-2. Not reset; the
  // first two lines after SOF/reset overwrite every column before any window
  // reads them.
  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];
  logic [7:0] tap_top;
  logic [7:0] tap_mid;

  // Column shift register, index 0 = oldest column (col-2), 2 = newest.
  logic [7:0] sr_top [3];
  logic [7:0] sr_mid [3];
  logic [7:0] sr_bot [3];

  // Registered window, row-major, index 0 = top-left.
  logic [7:0] win_q [9];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign cur_col  = in_sof ? '0 : col;
  assign cur_row  = in_sof ? '0 : row;
  assign tap_top  = lb2[cur_col];
  assign tap_mid  = lb1[cur_col];
  assign produce  = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
  assign last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Advance the raster position on each accepted pixel, wrapping at line/frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Line buffer update: the line-1 entry ages into line-2, the new pixel becomes line-1.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[cur_col] <= tap_mid;
      lb1[cur_col] <= in_pixel;
    end
  end

  // Shift the three-line column stack left by one column per accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        sr_top[i] <= '0;
        sr_mid[i] <= '0;
        sr_bot[i] <= '0;
      end
    end else if (accept) begin
      sr_top[0] <= sr_top[1];
      sr_top[1] <= sr_top[2];
      sr_top[2] <= tap_top;
      sr_mid[0] <= sr_mid[1];
      sr_mid[1] <= sr_mid[2];
      sr_mid[2] <= tap_mid;
      sr_bot[0] <= sr_bot[1];
      sr_bot[1] <= sr_bot[2];
      sr_bot[2] <= in_pixel;
    end
  end

  // Output register: load a new window on produce (even while the old one is
  // being taken, so there is no bubble), otherwise drain on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (produce) begin
      win_q[0]   <= sr_top[1];
      win_q[1]   <= sr_top[2];
      win_q[2]   <= tap_top;
      win_q[3]   <= sr_mid[1];
      win_q[4]   <= sr_mid[2];
      win_q[5]   <= tap_mid;
      win_q[6]   <= sr_bot[1];
      win_q[7]   <= sr_bot[2];
      win_q[8]   <= in_pixel;
      out_valid  <= 1'b1;
      frame_done <= last_pix;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  assign out_pixel_1 = win_q[0];
  assign out_pixel_2 = win_q[1];
  assign out_pixel_3 = win_q[2];
  assign out_pixel_4 = win_q[3];
  assign out_pixel_5 = win_q[4];
  assign out_pixel_6 = win_q[5];
  assign out_pixel_7 = win_q[6];
  assign out_pixel_8 = win_q[7];
  assign out_pixel_9 = win_q[8];

endmodule
